spi_memory_burst: RTL and testbench



---
 rtl/spi_memory_pkg.sv | 30 +++
 rtl/spi_pin_sync.sv | 45 ++++
 rtl/spi_memory_burst.sv | 205 ++++++++++++++++++++
 tb/tb_spi_memory_burst.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_memory_pkg.sv
// Shared types and constants for the burst SPI memory slave.
// Contents: FSM state enum, header/RW constants, leds bit indices,
// and a helper that derives the header length from the address width.
`timescale 1ns/1ps
package spi_memory_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    READ_LOAD,
    READ_SHIFT,
    WRITE_SHIFT,
    WRITE_COMMIT
  } state_e;

  localparam int unsigned DEF_ADDR_WIDTH = 7;
  localparam int unsigned HDR_BITS       = DEF_ADDR_WIDTH + 1;
  localparam logic        RW_READ        = 1'b1;

  localparam int unsigned LED_ACTIVE = 0;
  localparam int unsigned LED_READ   = 1;
  localparam int unsigned LED_WROTE  = 2;
  localparam int unsigned LED_ABORT  = 3;

  // Header is one R/W bit followed by the address.
  function automatic int unsigned hdr_bits(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchroniser with registered edge detection.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   i_pin        : asynchronous pin input
//   o_level      : synchronised level
//   o_rise/o_fall: one-clk pulses on synchronised rising/falling edges
// Parameters: STAGES (>= 2) flops in the chain, RST_VAL idle pin level.
`timescale 1ns/1ps
module spi_pin_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_last;
  logic              r_rise;
  logic              r_fall;

  // Edges come from the last two synchronised samples; level stays aligned with them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_last <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_last <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_last;
      r_fall <= ~r_sync[STAGES-1] & r_last;
    end
  end

  assign o_level = r_last;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave in front of an inferred synchronous RAM with burst
// read/write and wrap-around address auto-increment.
// Ports:
//   clk, reset_n  : system clock, async active-low reset
//   sclk_pin      : SPI clock (CPOL=0, CPHA=0)
//   cs_pin        : chip select, active low
//   mosi_pin      : serial data in, MSB first
//   miso_pin      : serial data out, high-Z outside a frame
//   leds[3:0]     : {abort sticky, write sticky, read frame, frame active}
//   wp_n          : write protect, active low (only with SPI_MEM_WRITE_PROTECT_EN)
// Optional feature macro: SPI_MEM_WRITE_PROTECT_EN.
`timescale 1ns/1ps
module spi_memory_burst
  import spi_memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned DEPTH       = 2**ADDR_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
`ifdef SPI_MEM_WRITE_PROTECT_EN
  input  logic       wp_n,
`endif
  output logic       miso_pin,
  output logic [3:0] leds
);

  localparam int unsigned HDR_W    = hdr_bits(ADDR_WIDTH);
  localparam int unsigned MAX_BITS = (HDR_W > DATA_WIDTH) ? HDR_W : DATA_WIDTH;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .i_pin(sclk_pin),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .i_pin(cs_pin),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .i_pin(mosi_pin),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = ^{w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};

  state_e                  r_state;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [HDR_W-1:0]        r_hdr;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_load_ph;
  logic                    r_miso;
  logic                    r_miso_oe;
  logic [3:0]              r_leds;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [HDR_W-1:0]        w_hdr_next;
  logic [ADDR_WIDTH-1:0]   w_addr_inc;
  logic                    w_wp_ok;
  logic                    w_we;

`ifdef SPI_MEM_WRITE_PROTECT_EN
  assign w_wp_ok = wp_n;
`else
  assign w_wp_ok = 1'b1;
`endif

  assign w_hdr_next = {r_hdr[HDR_W-2:0], w_mosi};
  assign w_addr_inc = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);
  // Commit is a single-cycle state, so the write strobe follows it directly;
  // an async reset leaving it cancels the write of the word in flight.
  assign w_we       = (r_state == WRITE_COMMIT) && w_wp_ok;

  // RAM: unreset, read port samples every cycle at the current address.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_addr] <= r_shift;
    end
    r_rd_data <= r_mem[r_addr];
  end

  // Frame FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_addr    <= '0;
      r_hdr     <= '0;
      r_shift   <= '0;
      r_load_ph <= 1'b0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
      r_leds    <= '0;
    end else if (w_cs_rise && (r_state != IDLE)) begin
      // End of frame: a half-shifted write word is dropped, an in-flight commit finishes.
      r_state              <= IDLE;
      r_bit_cnt            <= '0;
      r_load_ph            <= 1'b0;
      r_miso               <= 1'b0;
      r_miso_oe            <= 1'b0;
      r_leds[LED_ACTIVE]   <= 1'b0;
      r_leds[LED_READ]     <= 1'b0;
      if ((r_state == WRITE_SHIFT) && (r_bit_cnt != '0)) begin
        r_leds[LED_ABORT] <= 1'b1;
      end
      if (r_state == WRITE_COMMIT) begin
        r_addr <= w_addr_inc;
        if (w_wp_ok) r_leds[LED_WROTE] <= 1'b1;
        else         r_leds[LED_ABORT] <= 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state            <= HEADER;
            r_bit_cnt          <= '0;
            r_miso             <= 1'b0;
            r_miso_oe          <= 1'b1;
            r_leds[LED_ACTIVE] <= 1'b1;
            r_leds[LED_READ]   <= 1'b0;
          end
        end
        HEADER: begin
          if (w_sclk_rise) begin
            r_hdr <= w_hdr_next;
            if (r_bit_cnt == CNT_W'(HDR_W - 1)) begin
              r_bit_cnt <= '0;
              r_addr    <= w_hdr_next[ADDR_WIDTH-1:0];
              if (w_hdr_next[HDR_W-1] == RW_READ) begin
                r_state          <= READ_LOAD;
                r_load_ph        <= 1'b0;
                r_leds[LED_READ] <= 1'b1;
              end else begin
                r_state <= WRITE_SHIFT;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        READ_LOAD: begin
          // Phase 0 lets the RAM read land in r_rd_data, phase 1 loads the shifter.
          if (!r_load_ph) begin
            r_load_ph <= 1'b1;
          end else begin
            r_load_ph <= 1'b0;
            r_shift   <= r_rd_data;
            r_state   <= READ_SHIFT;
          end
        end
        READ_SHIFT: begin
          if (w_sclk_fall) begin
            r_miso  <= r_shift[DATA_WIDTH-1];
            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              r_bit_cnt <= '0;
              r_addr    <= w_addr_inc;
              r_state   <= READ_LOAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        WRITE_SHIFT: begin
          if (w_sclk_rise) begin
            r_shift <= {r_shift[DATA_WIDTH-2:0], w_mosi};
            if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= WRITE_COMMIT;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        WRITE_COMMIT: begin
          r_addr  <= w_addr_inc;
          r_state <= WRITE_SHIFT;
          if (w_wp_ok) r_leds[LED_WROTE] <= 1'b1;
          else         r_leds[LED_ABORT] <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign miso_pin = r_miso_oe ? r_miso : 1'bz;
  assign leds     = r_leds;

endmodule

// File: tb/tb_spi_memory_burst.sv
// Bench for spi_memory_burst: an 8/7 instance and a 16/4 instance share
// sclk/mosi, each has its own chip select. A bench-side memory/leds model
// predicts miso bits and leds; literal expectations pin the model.
`timescale 1ns/1ps
module tb_spi_memory_burst;

  localparam int HALF = 80;

  logic       clk;
  logic       reset_n;
  logic       sclk;
  logic       mosi;
  logic       cs_a;
  logic       cs_b;
  wire        miso_a;
  wire        miso_b;
  logic [3:0] leds_a;
  logic [3:0] leds_b;
`ifdef SPI_MEM_WRITE_PROTECT_EN
  logic       wp_n;
`endif

  // Undriven miso reads back as 1, so tri-state is distinguishable from driven 0.
  pullup (miso_a);
  pullup (miso_b);

  spi_memory_burst u_dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .sclk_pin (sclk),
    .cs_pin   (cs_a),
    .mosi_pin (mosi),
`ifdef SPI_MEM_WRITE_PROTECT_EN
    .wp_n     (wp_n),
`endif
    .miso_pin (miso_a),
    .leds     (leds_a)
  );

  spi_memory_burst #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .sclk_pin (sclk),
    .cs_pin   (cs_b),
    .mosi_pin (mosi),
`ifdef SPI_MEM_WRITE_PROTECT_EN
    .wp_n     (wp_n),
`endif
    .miso_pin (miso_b),
    .leds     (leds_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_bad;
  int          sel;
  bit          bit_chk;
  bit          exp_bit;
  bit          leds_chk;
  bit          idle_chk;
  bit          rd_act;
  int unsigned mem [2][128];
  bit          s2 [2];
  bit          s3 [2];
  int unsigned wr_q[$];
  int unsigned rd_q[$];
  logic        cmp_miso;
  logic [3:0]  cmp_leds;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic bit wp_active();
`ifdef SPI_MEM_WRITE_PROTECT_EN
    return !wp_n;
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle compare against the model whenever outputs are meaningful.
  always @(negedge clk) begin
    cmp_miso = (sel != 0) ? miso_b : miso_a;
    cmp_leds = (sel != 0) ? leds_b : leds_a;
    if (bit_chk && sclk) check("miso_bit", 32'(cmp_miso), 32'(exp_bit));
    if (idle_chk) begin
      check("miso_idle", 32'(cmp_miso), 32'd1);
      check("leds_idle", 32'(cmp_leds), 32'({s3[sel], s2[sel], 2'b00}));
    end
    if (leds_chk) check("leds_frame", 32'(cmp_leds), 32'({s3[sel], s2[sel], rd_act, 1'b1}));
  end

  task automatic set_cs(input logic v);
    if (sel != 0) cs_b = v;
    else          cs_a = v;
  endtask

  // One SPI bit: set mosi, rising edge (master samples miso), falling edge.
  task automatic sbit(input bit b, output bit got);
    mosi = b;
    #(HALF);
    sclk = 1'b1;
    #10;
    got = (sel != 0) ? miso_b : miso_a;
    #(HALF - 10);
    sclk = 1'b0;
  endtask

  task automatic send_header(input bit rd, input int unsigned addr, input int unsigned aw);
    bit g;
    bit_chk = 1'b1;
    exp_bit = 1'b0;
    sbit(rd, g);
    for (int i = int'(aw) - 1; i >= 0; i--) sbit(addr[i], g);
  endtask

  // Full frame; writes take data from wr_q, reads put words into rd_q.
  task automatic frame(input bit rd, input int unsigned addr, input int unsigned nwords,
                       input int unsigned extra);
    int unsigned dw, aw, a, w, v;
    bit g;
    dw = (sel != 0) ? 16 : 8;
    aw = (sel != 0) ? 4 : 7;
    a  = addr;
    rd_q.delete();
    idle_chk = 1'b0;
    @(negedge clk);
    set_cs(1'b0);
    #(HALF);
    send_header(rd, addr, aw);
    bit_chk = rd;
    if (rd) begin
      rd_act   = 1'b1;
      leds_chk = 1'b1;
      for (int k = 0; k < int'(nwords); k++) begin
        w = mem[sel][a];
        v = 0;
        for (int i = int'(dw) - 1; i >= 0; i--) begin
          exp_bit = w[i];
          sbit(1'b0, g);
          v = (v << 1) | 32'(g);
        end
        rd_q.push_back(v);
        a = (a + 1) % (32'd1 << aw);
      end
    end else begin
      foreach (wr_q[k]) begin
        w = wr_q[k];
        for (int i = int'(dw) - 1; i >= 0; i--) sbit(w[i], g);
        if (wp_active()) s3[sel] = 1'b1;
        else begin
          mem[sel][a] = w;
          s2[sel]     = 1'b1;
        end
        a = (a + 1) % (32'd1 << aw);
      end
      for (int i = 0; i < int'(extra); i++) sbit(1'b1, g);
      if (extra > 0) s3[sel] = 1'b1;
    end
    bit_chk  = 1'b0;
    leds_chk = 1'b0;
    rd_act   = 1'b0;
    #(HALF);
    set_cs(1'b1);
    #100;
    idle_chk = 1'b1;
  endtask

  initial begin
    bit g;
    n_cmp = 0; n_bad = 0; sel = 0;
    bit_chk = 0; exp_bit = 0; leds_chk = 0; idle_chk = 0; rd_act = 0;
    s2[0] = 0; s2[1] = 0; s3[0] = 0; s3[1] = 0;
    reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1;
`ifdef SPI_MEM_WRITE_PROTECT_EN
    wp_n = 1'b1;
`endif
    // Reset with cs high, then release: stays idle.
    #20 idle_chk = 1'b1;
    #100 reset_n = 1'b1;
    #200;
    check("rst_leds", 32'(leds_a), 32'h0);
    check("rst_miso", 32'(miso_a), 32'd1);

    // Single write then read.
    wr_q = '{32'hA7};
    frame(1'b0, 32'h05, 1, 0);
    frame(1'b1, 32'h05, 1, 0);
    check("rd_05", rd_q[0], 32'hA7);
    check("leds_wrote", 32'(leds_a), 32'h4);

    // Burst write/read across the top-of-memory wrap.
    wr_q = '{32'h11, 32'h22, 32'h33};
    frame(1'b0, 32'h7E, 3, 0);
    frame(1'b1, 32'h7E, 3, 0);
    check("burst_7e", rd_q[0], 32'h11);
    check("burst_7f", rd_q[1], 32'h22);
    check("burst_00", rd_q[2], 32'h33);
    frame(1'b1, 32'h00, 1, 0);
    check("wrap_00", rd_q[0], 32'h33);

    // Abort: 3 stray bits after the header leave mem[0x10] alone.
    wr_q = '{32'h5A};
    frame(1'b0, 32'h10, 1, 0);
    wr_q.delete();
    frame(1'b0, 32'h10, 0, 3);
    check("leds_abort", 32'(leds_a), 32'hC);
    frame(1'b1, 32'h10, 1, 0);
    check("abort_10", rd_q[0], 32'h5A);

    // Reset asserted during the 6th data bit of a write to 0x05.
    idle_chk = 1'b0;
    @(negedge clk);
    cs_a = 1'b0;
    #(HALF);
    send_header(1'b0, 32'h05, 7);
    bit_chk = 1'b0;
    for (int i = 0; i < 5; i++) sbit(1'b0, g);
    mosi = 1'b0;
    #(HALF);
    sclk = 1'b1;
    #20 reset_n = 1'b0;
    s2[0] = 0; s2[1] = 0; s3[0] = 0; s3[1] = 0;
    #(HALF - 20) sclk = 1'b0;
    cs_a = 1'b1;
    #50;
    idle_chk = 1'b1;
    check("midrst_miso", 32'(miso_a), 32'd1);
    check("midrst_leds", 32'(leds_a), 32'h0);
    #100 reset_n = 1'b1;
    #200;
    frame(1'b1, 32'h05, 1, 0);
    check("midrst_05", rd_q[0], 32'hA7);

    // 16-bit word / 4-bit address instance with wrap.
    sel = 1;
    wr_q = '{32'hBEEF, 32'h1234};
    frame(1'b0, 32'hF, 2, 0);
    frame(1'b1, 32'hF, 2, 0);
    check("b_rd_f", rd_q[0], 32'hBEEF);
    check("b_rd_0", rd_q[1], 32'h1234);
    check("b_leds", 32'(leds_b), 32'h4);

`ifdef SPI_MEM_WRITE_PROTECT_EN
    wp_n = 1'b0;
    wr_q = '{32'h0000};
    frame(1'b0, 32'hF, 1, 0);
    wp_n = 1'b1;
    check("wp_leds", 32'(leds_b), 32'hC);
    frame(1'b1, 32'hF, 1, 0);
    check("wp_rd_f", rd_q[0], 32'hBEEF);
`endif

    // Instance A untouched by instance B traffic.
    sel = 0;
    frame(1'b1, 32'h7F, 1, 0);
    check("a_rd_7f", rd_q[0], 32'h22);

    idle_chk = 1'b0;
    #50;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
